// File: rtl/health_pkg.sv
// ----------------------------------------------------------------------------
// health_pkg
// Shared types and constants for the round/health controller:
//   - state_t      : round sequencing states
//   - WINNER_*     : encoding of the winner output
//   - PTR_*        : round-robin pointer encoding for the damage arbiter
//   - HEALTH_W     : width of health values
//   - sat_inc2()   : 2-bit saturating increment used for round-win counters
// ----------------------------------------------------------------------------
package health_pkg;

    localparam int HEALTH_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FIGHT      = 3'd1,
        ST_DRAIN      = 3'd2,
        ST_KO_FLASH   = 3'd3,
        ST_ROUND_END  = 3'd4,
        ST_MATCH_OVER = 3'd5
    } state_t;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_L    = 2'b01;
    localparam logic [1:0] WINNER_R    = 2'b10;

    localparam logic PTR_L = 1'b0;
    localparam logic PTR_R = 1'b1;

    function automatic logic [1:0] sat_inc2(input logic [1:0] val);
        return (val == 2'd3) ? 2'd3 : val + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin arbiter with a registered priority pointer.
// At most one grant per cycle. A lone request is granted regardless of the
// pointer and leaves it unchanged; on contention the pointer side wins and
// the pointer flips to the other side.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset (pointer -> left)
//   en              : grants are only issued while en is high
//   req_l, req_r    : requests from the left / right side
//   gnt_l, gnt_r    : combinational one-hot (or zero) grants
// ----------------------------------------------------------------------------
module rr_arbiter2
    import health_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_l,
    input  logic req_r,
    output logic gnt_l,
    output logic gnt_r
);

    logic ptr_q, ptr_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves a value unassigned and infers a latch.
        gnt_l = 1'b0;
        gnt_r = 1'b0;
        ptr_d = ptr_q;
        if (en) begin
            if (req_l && req_r) begin
                gnt_l = (ptr_q == PTR_L);
                gnt_r = (ptr_q == PTR_R);
                ptr_d = ~ptr_q;
            end else begin
                gnt_l = req_l;
                gnt_r = req_r;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples its input from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PTR_L;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/health_round_ctrl.sv
// ----------------------------------------------------------------------------
// health_round_ctrl
// Round/health controller feeding the status bar. Damage requests from both
// fighters share one saturating subtractor through a round-robin arbiter.
// A KO waits for the loser's animated health bar to drain to zero, then runs
// a tick-paced KO flash, counts the round win and ends the match once a
// fighter reaches ROUNDS_TO_WIN.
//
// Optional build macro ROUND_TIMER_EN adds a tick-driven round timer and the
// timer_val output; when the timer expires the healthier fighter wins the
// round (tie: no winner).
//
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   tick                          : one-cycle animation-rate pulse
//   start                         : begin round / new match (level)
//   hit_{l,r}_valid/_dmg/_ready   : damage request handshakes
//   final_health_{l,r}            : animated health from the status bar
//   curr_health_{l,r}             : registered health values
//   round_active, ko_flash        : FIGHT indicator, KO text enable
//   winner, wins_l, wins_r        : round result and win counters
//   timer_val (ROUND_TIMER_EN)    : remaining round ticks
//   match_over                    : match finished
// ----------------------------------------------------------------------------
module health_round_ctrl
    import health_pkg::*;
#(
`ifdef ROUND_TIMER_EN
    parameter int unsigned         ROUND_TICKS    = 99,
`endif
    parameter logic [HEALTH_W-1:0] MAX_HEALTH     = 9'd300,
    parameter int unsigned         KO_FLASH_TICKS = 6,
    parameter int unsigned         ROUNDS_TO_WIN  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                start,
    input  logic                hit_l_valid,
    input  logic [7:0]          hit_l_dmg,
    output logic                hit_l_ready,
    input  logic                hit_r_valid,
    input  logic [7:0]          hit_r_dmg,
    output logic                hit_r_ready,
    input  logic [HEALTH_W-1:0] final_health_l,
    input  logic [HEALTH_W-1:0] final_health_r,
    output logic [HEALTH_W-1:0] curr_health_l,
    output logic [HEALTH_W-1:0] curr_health_r,
    output logic                round_active,
    output logic                ko_flash,
    output logic [1:0]          winner,
    output logic [1:0]          wins_l,
    output logic [1:0]          wins_r,
`ifdef ROUND_TIMER_EN
    output logic [6:0]          timer_val,
`endif
    output logic                match_over
);

    localparam int FLASH_W = $clog2(KO_FLASH_TICKS + 1);
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(KO_FLASH_TICKS - 1);
    localparam logic [1:0] WINS_NEEDED = 2'(ROUNDS_TO_WIN);

    state_t               state_q, state_d;
    logic [HEALTH_W-1:0]  health_l_q, health_l_d;
    logic [HEALTH_W-1:0]  health_r_q, health_r_d;
    logic [1:0]           winner_q, winner_d;
    logic [1:0]           wins_l_q, wins_l_d;
    logic [1:0]           wins_r_q, wins_r_d;
    logic                 ko_flash_q, ko_flash_d;
    logic [FLASH_W-1:0]   flash_cnt_q, flash_cnt_d;
    // High only in the first cycle of ROUND_END, when the win is counted.
    logic                 end_entry_q, end_entry_d;
    logic                 go_fight;

`ifdef ROUND_TIMER_EN
    localparam logic [6:0] TIMER_INIT = 7'(ROUND_TICKS);
    logic [6:0] timer_q, timer_d;
`endif

    logic gnt_l, gnt_r;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == ST_FIGHT),
        .req_l (hit_l_valid),
        .req_r (hit_r_valid),
        .gnt_l (gnt_l),
        .gnt_r (gnt_r)
    );

    // Single shared saturating subtractor, operands steered by the grant.
    logic [HEALTH_W-1:0] sub_a, sub_b, sub_res;
    assign sub_a   = gnt_r ? health_r_q : health_l_q;
    assign sub_b   = {1'b0, (gnt_r ? hit_r_dmg : hit_l_dmg)};
    assign sub_res = (sub_a > sub_b) ? (sub_a - sub_b) : '0;

    always_comb begin
        state_d     = state_q;
        health_l_d  = health_l_q;
        health_r_d  = health_r_q;
        winner_d    = winner_q;
        wins_l_d    = wins_l_q;
        wins_r_d    = wins_r_q;
        ko_flash_d  = ko_flash_q;
        flash_cnt_d = flash_cnt_q;
        end_entry_d = 1'b0;
        go_fight    = 1'b0;
`ifdef ROUND_TIMER_EN
        timer_d     = timer_q;
`endif

        case (state_q)
            ST_IDLE: begin
                go_fight = start;
            end

            ST_FIGHT: begin
                if (gnt_l) begin
                    health_l_d = sub_res;
                    if (sub_res == '0) begin
                        state_d  = ST_DRAIN;
                        winner_d = WINNER_R;
                    end
                end else if (gnt_r) begin
                    health_r_d = sub_res;
                    if (sub_res == '0) begin
                        state_d  = ST_DRAIN;
                        winner_d = WINNER_L;
                    end
                end
`ifdef ROUND_TIMER_EN
                // A KO in the same cycle already moved state_d to DRAIN and
                // takes priority over timer expiry.
                if (tick && (state_d == ST_FIGHT)) begin
                    timer_d = timer_q - 7'd1;
                    if (timer_q <= 7'd1) begin
                        timer_d     = '0;
                        state_d     = ST_KO_FLASH;
                        ko_flash_d  = 1'b1;
                        flash_cnt_d = '0;
                        if (health_l_d > health_r_d)      winner_d = WINNER_L;
                        else if (health_r_d > health_l_d) winner_d = WINNER_R;
                        else                              winner_d = WINNER_NONE;
                    end
                end
`endif
            end

            ST_DRAIN: begin
                // Wait for the loser's animated bar, not the registered value.
                if (((winner_q == WINNER_L) ? final_health_r : final_health_l) == '0) begin
                    state_d     = ST_KO_FLASH;
                    ko_flash_d  = 1'b1;
                    flash_cnt_d = '0;
                end
            end

            ST_KO_FLASH: begin
                if (tick) begin
                    if (flash_cnt_q == FLASH_LAST) begin
                        state_d     = ST_ROUND_END;
                        ko_flash_d  = 1'b0;
                        end_entry_d = 1'b1;
                    end else begin
                        flash_cnt_d = flash_cnt_q + 1'b1;
                        ko_flash_d  = ~ko_flash_q;
                    end
                end
            end

            ST_ROUND_END: begin
                if (end_entry_q) begin
                    if (winner_q == WINNER_L) wins_l_d = sat_inc2(wins_l_q);
                    if (winner_q == WINNER_R) wins_r_d = sat_inc2(wins_r_q);
                    if (((winner_q == WINNER_L) && (wins_l_d == WINS_NEEDED)) ||
                        ((winner_q == WINNER_R) && (wins_r_d == WINS_NEEDED))) begin
                        state_d = ST_MATCH_OVER;
                    end else begin
                        go_fight = start;
                    end
                end else begin
                    go_fight = start;
                end
            end

            ST_MATCH_OVER: begin
                if (start) begin
                    wins_l_d = '0;
                    wins_r_d = '0;
                    go_fight = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (go_fight) begin
            state_d    = ST_FIGHT;
            health_l_d = MAX_HEALTH;
            health_r_d = MAX_HEALTH;
            winner_d   = WINNER_NONE;
`ifdef ROUND_TIMER_EN
            timer_d    = TIMER_INIT;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            health_l_q  <= MAX_HEALTH;
            health_r_q  <= MAX_HEALTH;
            winner_q    <= WINNER_NONE;
            wins_l_q    <= '0;
            wins_r_q    <= '0;
            ko_flash_q  <= 1'b0;
            flash_cnt_q <= '0;
            end_entry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            health_l_q  <= health_l_d;
            health_r_q  <= health_r_d;
            winner_q    <= winner_d;
            wins_l_q    <= wins_l_d;
            wins_r_q    <= wins_r_d;
            ko_flash_q  <= ko_flash_d;
            flash_cnt_q <= flash_cnt_d;
            end_entry_q <= end_entry_d;
        end
    end

`ifdef ROUND_TIMER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= TIMER_INIT;
        end else begin
            timer_q <= timer_d;
        end
    end
    assign timer_val = timer_q;
`endif

    assign hit_l_ready   = gnt_l;
    assign hit_r_ready   = gnt_r;
    assign curr_health_l = health_l_q;
    assign curr_health_r = health_r_q;
    assign round_active  = (state_q == ST_FIGHT);
    assign match_over    = (state_q == ST_MATCH_OVER);
    assign ko_flash      = ko_flash_q;
    assign winner        = winner_q;
    assign wins_l        = wins_l_q;
    assign wins_r        = wins_r_q;

endmodule
